// File: rtl/mips_mem_responder_pkg.sv
// Shared types, field widths and helpers for the MIPS memory responder.
// The responder top, its storage array and the bench import this package.
package mips_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int STRB_W          = 4;
    localparam int CNT_W           = 4;
    localparam int DEFAULT_LATENCY = 2;
    localparam int DEFAULT_DEPTH   = 1024;

    // Misaligned byte address, or any address bit above the word-index field set.
    function automatic logic addr_error(input logic [ADDR_W-1:0] addr,
                                        input int unsigned       idx_w);
        logic [ADDR_W-1:0] hi_mask;
        hi_mask = ~((ADDR_W'(1) << (idx_w + 32'd2)) - ADDR_W'(1));
        return (addr[1:0] != 2'b00) || ((addr & hi_mask) != {ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/mips_mem_sram_1p.sv
// Single-port word array with byte-lane write enables and a registered read.
// Contents are deliberately left uninitialised and survive reset.
module mips_mem_sram_1p
    import mips_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [STRB_W-1:0] be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_r;

    // Byte-lane write port
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (be[i]) begin
                    mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (en && !we) begin
            rdata_r <= mem_r[idx];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mips_mem_responder.sv
// Request/response front end for the multi-cycle MIPS core's memory port:
// one request in flight, fixed LATENCY, misaligned/out-of-range flagging.
module mips_mem_responder
    import mips_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [STRB_W-1:0] req_strobe,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LATENCY - 1);

    mem_state_t        state_r;
    mem_state_t        state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              ready_r;

    logic              cap_write_r;
    logic              cap_err_r;
    logic [ADDR_W-1:0] cap_addr_r;
    logic [STRB_W-1:0] cap_strobe_r;
    logic [DATA_W-1:0] cap_wdata_r;

    logic              resp_valid_r;
    logic              resp_err_r;
    logic [DATA_W-1:0] resp_rdata_r;

    logic              accept_s;
    logic              enter_resp_s;
    logic              mem_en_s;
    logic              acc_write_s;
    logic              acc_err_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [STRB_W-1:0] acc_strobe_s;
    logic [DATA_W-1:0] acc_wdata_s;
    logic [DATA_W-1:0] sram_rdata_s;

    assign accept_s = req_valid & ready_r;

    // Next-state and counter logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    cnt_next_s   = LOAD_CNT;
                    state_next_s = (LATENCY == 1) ? RESP : BUSY;
                end else begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                // A zero count here cannot occur legally; leave rather than wrap.
                if (cnt_r <= CNT_W'(1)) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = RESP;
                end else begin
                    cnt_next_s   = cnt_r - CNT_W'(1);
                    state_next_s = BUSY;
                end
            end
            RESP: begin
                cnt_next_s   = {CNT_W{1'b0}};
                state_next_s = IDLE;
            end
            default: begin
                cnt_next_s   = {CNT_W{1'b0}};
                state_next_s = IDLE;
            end
        endcase
    end

    // State, counter and ready registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            ready_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            ready_r <= (state_next_s == IDLE);
        end
    end

    // Request capture on acceptance
    always_ff @(posedge clk) begin
        if (!reset) begin
            cap_write_r  <= 1'b0;
            cap_err_r    <= 1'b0;
            cap_addr_r   <= {ADDR_W{1'b0}};
            cap_strobe_r <= {STRB_W{1'b0}};
            cap_wdata_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            cap_write_r  <= req_write;
            cap_err_r    <= addr_error(req_addr, IDX_W);
            cap_addr_r   <= req_addr;
            cap_strobe_r <= req_strobe;
            cap_wdata_r  <= req_wdata;
        end else begin
            cap_write_r  <= cap_write_r;
            cap_err_r    <= cap_err_r;
            cap_addr_r   <= cap_addr_r;
            cap_strobe_r <= cap_strobe_r;
            cap_wdata_r  <= cap_wdata_r;
        end
    end

    // With LATENCY = 1 the array is accessed on the acceptance edge itself,
    // before the capture registers hold the request, so take the live inputs.
    always_comb begin
        if (state_r == IDLE) begin
            acc_write_s  = req_write;
            acc_addr_s   = req_addr;
            acc_strobe_s = req_strobe;
            acc_wdata_s  = req_wdata;
        end else begin
            acc_write_s  = cap_write_r;
            acc_addr_s   = cap_addr_r;
            acc_strobe_s = cap_strobe_r;
            acc_wdata_s  = cap_wdata_r;
        end
    end

    assign acc_err_s    = addr_error(acc_addr_s, IDX_W);
    assign enter_resp_s = (state_next_s == RESP) && (state_r != RESP);
    // Gating by reset drops a write that would land on a reset edge.
    assign mem_en_s     = reset & enter_resp_s & ~acc_err_s;

    mips_mem_sram_1p #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk   (clk),
        .reset (reset),
        .en    (mem_en_s),
        .we    (acc_write_s),
        .be    (acc_strobe_s),
        .idx   (acc_addr_s[IDX_W+1:2]),
        .wdata (acc_wdata_s),
        .rdata (sram_rdata_s)
    );

    // Response registers, loaded as RESP is left so data and error align with resp_valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= {DATA_W{1'b0}};
        end else if (state_r == RESP) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= cap_err_r;
            resp_rdata_r <= (cap_write_r || cap_err_r) ? {DATA_W{1'b0}} : sram_rdata_s;
        end else begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= resp_err_r;
            resp_rdata_r <= resp_rdata_r;
        end
    end

    assign req_ready  = ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: directed table, reset corner
// cases, a LATENCY = 1 instance, and randomized traffic against a word model.
module tb_mips_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid, req_write, req_ready, resp_valid, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_strobe;
    logic        l1_req_valid, l1_req_write, l1_req_ready, l1_resp_valid, l1_resp_err;
    logic [31:0] l1_req_addr, l1_req_wdata, l1_resp_rdata;
    logic [3:0]  l1_req_strobe;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [31:0] model_mem [int];

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          at;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    vec_t tbl [15];
    rsp_t l1_rsp [$];

    mips_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_strobe (req_strobe),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    mips_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (l1_req_valid),
        .req_write  (l1_req_write),
        .req_addr   (l1_req_addr),
        .req_strobe (l1_req_strobe),
        .req_wdata  (l1_req_wdata),
        .req_ready  (l1_req_ready),
        .resp_valid (l1_resp_valid),
        .resp_rdata (l1_resp_rdata),
        .resp_err   (l1_resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && l1_resp_valid) l1_rsp.push_back('{cyc, l1_resp_rdata, l1_resp_err});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: error rule, lane-wise store, whole-word load.
    task automatic model(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] er, output logic ee);
        logic [31:0] word;
        int          key;
        ee  = (a % 32'd4 != 32'd0) || ((a / 32'd4) >= 32'(DEPTH));
        er  = 32'd0;
        key = int'(a / 32'd4);
        if (!ee) begin
            word = model_mem.exists(key) ? model_mem[key] : 32'd0;
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (s[i]) word[8*i +: 8] = d[8*i +: 8];
                end
                model_mem[key] = word;
            end else begin
                er = word;
            end
        end
    endtask

    // One request on the LATENCY=2 instance; returns response and edges from acceptance.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input bit chk_ready,
                          output logic [31:0] rd, output logic re, output int lat);
        int n;
        @(negedge clk);
        req_write  = w;
        req_addr   = a;
        req_strobe = s;
        req_wdata  = d;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = ~w;
        req_addr   = $urandom;
        req_strobe = 4'($urandom);
        req_wdata  = $urandom;
        lat = 0;
        while (!resp_valid && lat < 50) begin
            if (chk_ready) check("ready_low_while_busy", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata;
        re = resp_err;
    endtask

    task automatic model_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] d);
        logic [31:0] er, rd;
        logic        ee, re;
        int          lat;
        model(w, a, s, d, er, ee);
        do_req(w, a, s, d, 1'b0, rd, re, lat);
        check("rnd_rdata", rd, er);
        check("rnd_err", {31'd0, re}, {31'd0, ee});
        check("rnd_latency", lat, LAT);
    endtask

    initial begin
        logic [31:0] rd, er;
        logic        re, ee, seen;
        int          lat, n, acc1, acc2;

        tbl[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0000_0000, 32'h11BB_33DD, 1'b0};
        tbl[5]  = '{1'b0, 32'h0000_0022, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[6]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
        tbl[7]  = '{1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        tbl[8]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000, 32'h0BAD_F00D, 1'b0};
        tbl[9]  = '{1'b1, 32'h0000_0030, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b0};
        tbl[10] = '{1'b1, 32'h0000_0030, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[11] = '{1'b0, 32'h0000_0030, 4'hF, 32'h0000_0000, 32'h1234_5678, 1'b0};
        tbl[12] = '{1'b1, 32'h0000_0040, 4'hF, 32'h55AA_55AA, 32'h0000_0000, 1'b0};
        tbl[13] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[14] = '{1'b0, 32'h0000_0040, 4'hF, 32'h0000_0000, 32'h55AA_55AA, 1'b0};

        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_strobe = 4'd0; req_wdata = 32'd0;
        l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_addr = 32'd0;
        l1_req_strobe = 4'd0; l1_req_wdata = 32'd0;

        // Requests presented during reset must not be taken.
        repeat (2) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_strobe = 4'hF;
        l1_req_valid = 1'b1; l1_req_write = 1'b1; l1_req_addr = 32'h10; l1_req_strobe = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        l1_req_valid = 1'b0;
        reset = 1'b1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_l1_req_ready", {31'd0, l1_req_ready}, 32'd1);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid || l1_resp_valid) seen = 1'b1;
        end
        check("no_accept_in_reset", {31'd0, seen}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            model(tbl[i].w, tbl[i].addr, tbl[i].strb, tbl[i].wdata, er, ee);
            do_req(tbl[i].w, tbl[i].addr, tbl[i].strb, tbl[i].wdata, 1'b1, rd, re, lat);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_err", i), {31'd0, re}, {31'd0, tbl[i].exp_err});
            check($sformatf("tbl%0d_latency", i), lat, LAT);
        end

        // Reset while BUSY abandons a write to 0x40.
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h40; req_strobe = 4'hF; req_wdata = 32'hCAFE_F00D;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("busy_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("busy_rst_resp_rdata", resp_rdata, 32'd0);
        check("busy_rst_resp_err", {31'd0, resp_err}, 32'd0);
        seen = resp_valid;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("busy_rst_no_resp", {31'd0, seen}, 32'd0);
        do_req(1'b0, 32'h40, 4'hF, 32'd0, 1'b0, rd, re, lat);
        check("busy_rst_read_0x40", rd, 32'h55AA_55AA);

        // Randomized traffic: fill words 0..15, then mixed loads, stores and bad addresses.
        for (int i = 0; i < 16; i++) model_req(1'b1, 32'(i * 4), 4'hF, $urandom);
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            int          kind;
            kind = int'($urandom_range(0, 9));
            a    = 32'($urandom_range(0, 15)) * 32'd4;
            if (kind == 0) a = a + 32'($urandom_range(1, 3));
            else if (kind == 1) a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
            else a = a;
            model_req(1'($urandom), a, 4'($urandom), $urandom);
        end

        // LATENCY = 1: responses one edge after acceptance, accepts two cycles apart.
        l1_rsp.delete();
        @(negedge clk);
        l1_req_write = 1'b1; l1_req_addr = 32'h8; l1_req_strobe = 4'hF;
        l1_req_wdata = 32'h1357_9BDF; l1_req_valid = 1'b1;
        n = 0;
        while (!l1_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc1 = cyc;
        @(negedge clk);
        l1_req_write = 1'b0; l1_req_wdata = 32'hFFFF_FFFF;
        check("l1_ready_low_in_resp", {31'd0, l1_req_ready}, 32'd0);
        n = 0;
        while (!l1_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc2 = cyc;
        @(posedge clk);
        #1;
        l1_req_valid = 1'b0;
        check("l1_accept_spacing", acc2 - acc1, 32'd2);
        repeat (4) @(negedge clk);
        check("l1_resp_count", l1_rsp.size(), 32'd2);
        if (l1_rsp.size() == 2) begin
            check("l1_wr_resp_time", l1_rsp[0].at, acc1 + 2);
            check("l1_wr_resp_rdata", l1_rsp[0].rdata, 32'd0);
            check("l1_rd_resp_time", l1_rsp[1].at, acc2 + 2);
            check("l1_rd_resp_rdata", l1_rsp[1].rdata, 32'h1357_9BDF);
            check("l1_rd_resp_err", {31'd0, l1_rsp[1].err}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
